// File: rtl/text_line_renderer_pkg.sv
// Shared constants and FSM encoding for the text line renderer.
// Also holds the char-code sanitiser used before font lookup.
package text_line_renderer_pkg;

  localparam int CHAR_W = 8;
  localparam int CHAR_H = 8;
  localparam int CODE_W = 5;

  localparam logic [CODE_W-1:0] CODE_SPACE = 5'd13;
  localparam logic [CODE_W-1:0] CODE_MAX   = 5'd24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  function automatic logic [CODE_W-1:0] sanitize_code(
    input logic [CODE_W-1:0] code
  );
    return (code > CODE_MAX) ? CODE_SPACE : code;
  endfunction

endpackage

// File: rtl/text_line_renderer_glyph_shift_reg.sv
// One glyph row held as a left-shifting register, MSB out first.
// Tracks the bit position to flag first and last pixel of the row.
module glyph_shift_reg
  import text_line_renderer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [CHAR_W-1:0] bitmap,
  input  logic              shift,
  output logic              bit_out,
  output logic              first_bit,
  output logic              last_bit
);

  logic [CHAR_W-1:0] shreg;
  logic [2:0]        bit_cnt;

  // load a fresh row or advance one pixel per accepted handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      shreg   <= bitmap;
      bit_cnt <= '0;
    end else if (shift) begin
      shreg   <= {shreg[CHAR_W-2:0], 1'b0};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  assign bit_out   = shreg[CHAR_W-1];
  assign first_bit = (bit_cnt == 3'd0);
  assign last_bit  = (bit_cnt == 3'(CHAR_W - 1));

endmodule

// File: rtl/text_line_renderer.sv
// Renders one line of text as an 8-row pixel raster stream.
// Row-major: every char of row 0, then row 1, ... up to row 7.
module text_line_renderer
  import text_line_renderer_pkg::*;
#(
  parameter int NUM_CHARS = 16,
  parameter int ADDR_W    = $clog2(NUM_CHARS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              text_rd,
  output logic [ADDR_W-1:0] text_addr,
  input  logic [CODE_W-1:0] text_code,
  output logic [CODE_W-1:0] rom_char_code,
  output logic [2:0]        rom_row,
  input  logic [CHAR_W-1:0] rom_bitmap,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_data,
  output logic              pix_sol,
  output logic              pix_eol,
  output logic              pix_eof,
  output logic              busy,
  output logic              done
);

  state_t state, next_state;

  logic [ADDR_W-1:0] char_cnt;
  logic [2:0]        row_cnt;
  logic [CODE_W-1:0] code_q;

  logic shift_bit;
  logic first_bit;
  logic last_bit;
  logic fire;
  logic char_end;
  logic last_char;
  logic last_row;

  assign fire      = (state == S_SHIFT) && pix_ready;
  assign char_end  = fire && last_bit;
  assign last_char = (char_cnt == ADDR_W'(NUM_CHARS - 1));
  assign last_row  = (row_cnt == 3'(CHAR_H - 1));

  glyph_shift_reg u_shreg (
    .clk       (clk),
    .rst       (rst),
    .load      (state == S_LOAD),
    .bitmap    (rom_bitmap),
    .shift     (fire),
    .bit_out   (shift_bit),
    .first_bit (first_bit),
    .last_bit  (last_bit)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // character/row position and the fetched char code
  always_ff @(posedge clk) begin
    if (rst) begin
      char_cnt <= '0;
      row_cnt  <= '0;
      code_q   <= '0;
    end else if (abort || (state == S_IDLE && start)) begin
      char_cnt <= '0;
      row_cnt  <= '0;
    end else begin
      if (state == S_WAIT) code_q <= text_code;
      if (char_end) begin
        if (!last_char) begin
          char_cnt <= char_cnt + ADDR_W'(1);
        end else if (!last_row) begin
          row_cnt  <= row_cnt + 3'd1;
          char_cnt <= '0;
        end
      end
    end
  end

  // next-state and Moore outputs; abort overrides every busy state
  always_comb begin
    next_state    = state;
    text_rd       = 1'b0;
    text_addr     = '0;
    rom_char_code = '0;
    rom_row       = '0;
    pix_valid     = 1'b0;
    pix_data      = 1'b0;
    pix_sol       = 1'b0;
    pix_eol       = 1'b0;
    pix_eof       = 1'b0;
    busy          = (state != S_IDLE);
    done          = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) next_state = S_FETCH;
      end
      S_FETCH: begin
        text_rd    = 1'b1;
        text_addr  = char_cnt;
        next_state = S_WAIT;
      end
      S_WAIT: begin
        next_state = S_LOAD;
      end
      S_LOAD: begin
        rom_char_code = sanitize_code(code_q);
        rom_row       = row_cnt;
        next_state    = S_SHIFT;
      end
      S_SHIFT: begin
        pix_valid = 1'b1;
        pix_data  = shift_bit;
        pix_sol   = first_bit && (char_cnt == '0);
        pix_eol   = last_bit && last_char;
        pix_eof   = last_bit && last_char && last_row;
        if (char_end) begin
          if (last_char && last_row) next_state = S_DONE;
          else                       next_state = S_FETCH;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
    if (abort && state != S_IDLE) next_state = S_IDLE;
  end

endmodule
